// File: rtl/uart_fifo.sv
// Ready/valid byte FIFO between the UART and the ALU paths, with first-word fall-through.
// Optional UART_FIFO_BYPASS_EN: an empty FIFO forwards valid_i/data_i straight to the read side.
module uart_fifo #(
  parameter int width_p = 8,
  parameter int depth_p = 16
) (
  input  logic                         clk_i,
  input  logic                         reset_ni,
  input  logic                         valid_i,
  input  logic [width_p-1:0]           data_i,
  output logic                         ready_o,
  output logic                         valid_o,
  output logic [width_p-1:0]           data_o,
  input  logic                         ready_i,
  output logic [$clog2(depth_p+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(depth_p);
  localparam int CNT_W = $clog2(depth_p + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(depth_p - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(depth_p);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};

  logic [width_p-1:0] mem_r [depth_p];
  logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r;
  logic [PTR_W-1:0]   wr_ptr_next_s, rd_ptr_next_s;
  logic [CNT_W-1:0]   count_r, count_next_s;
  logic               ready_r, valid_r;
  logic               bypass_s, pass_s, push_s, pop_s, wr_en_s, rd_en_s;

  // Handshake decode, read-side outputs and next-state computation.
  always_comb begin
`ifdef UART_FIFO_BYPASS_EN
    bypass_s = (count_r == CNT_ZERO) & valid_i & ready_r;
    data_o   = bypass_s ? data_i : mem_r[rd_ptr_r];
`else
    bypass_s = 1'b0;
    data_o   = mem_r[rd_ptr_r];
`endif
    valid_o = valid_r | bypass_s;
    push_s  = valid_i & ready_r;
    pop_s   = valid_o & ready_i;
    // A word consumed straight from data_i never touches storage.
    pass_s  = bypass_s & ready_i;
    wr_en_s = push_s & ~pass_s;
    rd_en_s = pop_s & ~pass_s;

    case ({wr_en_s, rd_en_s})
      2'b10:   count_next_s = count_r + CNT_W'(1);
      2'b01:   count_next_s = count_r - CNT_W'(1);
      default: count_next_s = count_r;
    endcase

    if (wr_en_s) begin
      wr_ptr_next_s = (wr_ptr_r == PTR_LAST) ? PTR_ZERO : wr_ptr_r + PTR_W'(1);
    end else begin
      wr_ptr_next_s = wr_ptr_r;
    end

    if (rd_en_s) begin
      rd_ptr_next_s = (rd_ptr_r == PTR_LAST) ? PTR_ZERO : rd_ptr_r + PTR_W'(1);
    end else begin
      rd_ptr_next_s = rd_ptr_r;
    end
  end

  // Pointer, occupancy and registered flag state.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
      ready_r  <= 1'b0;
      valid_r  <= 1'b0;
    end else begin
      wr_ptr_r <= wr_ptr_next_s;
      rd_ptr_r <= rd_ptr_next_s;
      count_r  <= count_next_s;
      ready_r  <= (count_next_s != CNT_FULL);
      valid_r  <= (count_next_s != CNT_ZERO);
    end
  end

  // Storage array, intentionally without reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= data_i;
    end
  end

  assign ready_o = ready_r;
  assign count_o = count_r;

endmodule

// File: tb/tb_uart_fifo.sv
// Scoreboard bench for uart_fifo: a depth-16 instance and a depth-5 instance.
// Expected bytes are queued when stimulus is issued; per-instance monitors pop and compare.
module tb_uart_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_vi, a_ri, a_ro, a_vo;
  logic [7:0] a_di, a_do;
  logic [4:0] a_cnt;
  logic       b_vi, b_ri, b_ro, b_vo;
  logic [7:0] b_di, b_do;
  logic [2:0] b_cnt;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_fifo #(.width_p(8), .depth_p(16)) dut_a (
    .clk_i(clk), .reset_ni(rst_n), .valid_i(a_vi), .data_i(a_di), .ready_o(a_ro),
    .valid_o(a_vo), .data_o(a_do), .ready_i(a_ri), .count_o(a_cnt));

  uart_fifo #(.width_p(8), .depth_p(5)) dut_b (
    .clk_i(clk), .reset_ni(rst_n), .valid_i(b_vi), .data_i(b_di), .ready_o(b_ro),
    .valid_o(b_vo), .data_o(b_do), .ready_i(b_ri), .count_o(b_cnt));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor A: every handshake on the read side must match the scoreboard head.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && a_vo === 1'b1 && a_ri === 1'b1) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_pop", 32'd1, 32'd0);
      end else begin
        chk("a_data_o", {24'd0, a_do}, {24'd0, qa.pop_front()});
      end
    end
  end

  // Monitor B, same for the depth-5 instance.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && b_vo === 1'b1 && b_ri === 1'b1) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_pop", 32'd1, 32'd0);
      end else begin
        chk("b_data_o", {24'd0, b_do}, {24'd0, qb.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    a_vi = 1'b0; a_ri = 1'b0; a_di = 8'h00;
    b_vi = 1'b0; b_ri = 1'b0; b_di = 8'h00;
    repeat (2) tick;
    chk("rst_count", {27'd0, a_cnt}, 32'd0);
    chk("rst_valid", {31'd0, a_vo}, 32'd0);
    chk("rst_ready", {31'd0, a_ro}, 32'd0);
    rst_n = 1'b1;
    tick;
    chk("ready_after_rst", {31'd0, a_ro}, 32'd1);
    chk("b_ready_after_rst", {31'd0, b_ro}, 32'd1);

    // Three words with the consumer stalled, then drained in order.
    a_vi = 1'b1;
    a_di = 8'h11; qa.push_back(8'h11); tick;
    a_di = 8'h22; qa.push_back(8'h22); tick;
    a_di = 8'h33; qa.push_back(8'h33); tick;
    a_vi = 1'b0;
    chk("t1_count3", {27'd0, a_cnt}, 32'd3);
    chk("t1_valid", {31'd0, a_vo}, 32'd1);
    chk("t1_head", {24'd0, a_do}, 32'h11);
    a_ri = 1'b1;
    repeat (3) tick;
    a_ri = 1'b0;
    chk("t1_count0", {27'd0, a_cnt}, 32'd0);
    chk("t1_empty", {31'd0, a_vo}, 32'd0);

    // Fill to 16; the 17th word must be refused, and a pop while full admits no push.
    for (int i = 0; i < 16; i++) begin
      a_vi = 1'b1; a_di = 8'(i); qa.push_back(8'(i));
      tick;
    end
    a_di = 8'hAA;
    chk("t2_full_count", {27'd0, a_cnt}, 32'd16);
    chk("t2_full_ready", {31'd0, a_ro}, 32'd0);
    tick;
    chk("t2_no_accept", {27'd0, a_cnt}, 32'd16);
    a_ri = 1'b1;
    tick;
    a_vi = 1'b0; a_ri = 1'b0;
    chk("t2_pop_count", {27'd0, a_cnt}, 32'd15);
    chk("t2_ready_back", {31'd0, a_ro}, 32'd1);
    chk("t2_head", {24'd0, a_do}, 32'h01);
    a_ri = 1'b1;
    repeat (15) tick;
    a_ri = 1'b0;
    chk("t2_drained", {27'd0, a_cnt}, 32'd0);

    // Steady push+pop at level 5 for 40 words, wrapping pointers twice.
    for (int i = 0; i < 5; i++) begin
      a_vi = 1'b1; a_di = 8'(8'h80 + i); qa.push_back(8'(8'h80 + i));
      tick;
    end
    a_ri = 1'b1;
    for (int i = 5; i < 40; i++) begin
      a_di = 8'(8'h80 + i); qa.push_back(8'(8'h80 + i));
      tick;
      chk("t3_level", {27'd0, a_cnt}, 32'd5);
    end
    a_vi = 1'b0;
    repeat (5) tick;
    a_ri = 1'b0;
    chk("t3_drained", {27'd0, a_cnt}, 32'd0);
    chk("t3_sb_empty", qa.size(), 32'd0);

    // Empty FIFO with producer and consumer both ready.
    a_vi = 1'b1; a_di = 8'h5A; a_ri = 1'b1; qa.push_back(8'h5A);
    @(negedge clk);
`ifdef UART_FIFO_BYPASS_EN
    chk("t4_bypass_valid", {31'd0, a_vo}, 32'd1);
    chk("t4_bypass_data", {24'd0, a_do}, 32'h5A);
`else
    chk("t4_no_bypass_valid", {31'd0, a_vo}, 32'd0);
`endif
    tick;
    a_vi = 1'b0;
`ifdef UART_FIFO_BYPASS_EN
    chk("t4_bypass_count", {27'd0, a_cnt}, 32'd0);
    chk("t4_bypass_after", {31'd0, a_vo}, 32'd0);
`else
    chk("t4_count1", {27'd0, a_cnt}, 32'd1);
    chk("t4_valid_next", {31'd0, a_vo}, 32'd1);
    chk("t4_data_next", {24'd0, a_do}, 32'h5A);
    tick;
`endif
    a_ri = 1'b0;
    chk("t4_end_count", {27'd0, a_cnt}, 32'd0);

    // Asynchronous reset mid-transfer at level 7.
    for (int i = 0; i < 7; i++) begin
      a_vi = 1'b1; a_di = 8'(8'h70 + i); qa.push_back(8'(8'h70 + i));
      tick;
    end
    chk("t5_count7", {27'd0, a_cnt}, 32'd7);
    a_di = 8'h77; a_ri = 1'b1;
    #2;
    rst_n = 1'b0;
    qa.delete();
    #1;
    chk("t5_rst_count", {27'd0, a_cnt}, 32'd0);
    chk("t5_rst_valid", {31'd0, a_vo}, 32'd0);
    chk("t5_rst_ready", {31'd0, a_ro}, 32'd0);
    a_vi = 1'b0; a_ri = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
    chk("t5_ready_back", {31'd0, a_ro}, 32'd1);
    a_vi = 1'b1; a_di = 8'hC3; qa.push_back(8'hC3);
    tick;
    a_vi = 1'b0;
    chk("t5_count1", {27'd0, a_cnt}, 32'd1);
    chk("t5_first_word", {24'd0, a_do}, 32'hC3);
    a_ri = 1'b1;
    tick;
    a_ri = 1'b0;
    chk("t5_empty", {27'd0, a_cnt}, 32'd0);

    // Depth-5 instance: fill, pop while full, then interleaved push/pop.
    for (int i = 0; i < 5; i++) begin
      b_vi = 1'b1; b_di = 8'(8'hB0 + i); qb.push_back(8'(8'hB0 + i));
      tick;
      chk("t6_fill_count", {29'd0, b_cnt}, 32'(i + 1));
    end
    chk("t6_full_ready", {31'd0, b_ro}, 32'd0);
    b_di = 8'hB5; b_ri = 1'b1;
    tick;
    chk("t6_full_pop", {29'd0, b_cnt}, 32'd4);
    for (int i = 5; i < 12; i++) begin
      b_di = 8'(8'hB0 + i); qb.push_back(8'(8'hB0 + i));
      tick;
      chk("t6_level", {29'd0, b_cnt}, 32'd4);
    end
    b_vi = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("t6_drain_count", {29'd0, b_cnt}, 32'(3 - i));
    end
    b_ri = 1'b0;
    chk("t6_empty", {31'd0, b_vo}, 32'd0);
    chk("t6_sb_empty", qb.size(), 32'd0);
    chk("a_sb_empty", qa.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
